// File: rtl/mult_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mult_seq_ctrl
// Description : Multi-cycle shift-add multiplier sequencer for MULT/MULTU.
//               Borrows the shared datapath adder through add_a/add_b/add_cin
//               and consumes add_s/add_cout in the same cycle.
//               The result is presented on hi_o/lo_o.
// Options     : MULT_ABORT_EN - adds the abort_i port. Asserting abort_i in
//               any active state cancels the operation.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             is_signed_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic [WIDTH-1:0] add_s_i,
   input  logic             add_cout_i,
`ifdef MULT_ABORT_EN
   input  logic             abort_i,
`endif
   output logic [WIDTH-1:0] add_a_o,
   output logic [WIDTH-1:0] add_b_o,
   output logic             add_cin_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ABS_A  = 3'd1;
   localparam logic [2:0] S_ABS_B  = 3'd2;
   localparam logic [2:0] S_MUL    = 3'd3;
   localparam logic [2:0] S_NEG_LO = 3'd4;
   localparam logic [2:0] S_NEG_HI = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sgn_q, sgn_d;     // operation is MULT
   logic             sa_q, sa_d;       // original sign of the multiplicand
   logic             neg_q, neg_d;     // final product must be negated
   logic             c_q, c_d;         // carry from low-word negation into high word
   logic             abort_w;

`ifdef MULT_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   // Moore status outputs decoded from the state register
   assign busy_o = (state_q != S_IDLE);
   assign done_o = (state_q == S_DONE);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

   // Next-state, datapath updates and adder operand steering
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      sgn_d     = sgn_q;
      sa_d      = sa_q;
      neg_d     = neg_q;
      c_d       = c_q;
      add_a_o   = '0;
      add_b_o   = '0;
      add_cin_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i && !abort_w) begin
               mcand_d = op_a_i;
               lo_d    = op_b_i;
               hi_d    = '0;
               cnt_d   = '0;
               sgn_d   = is_signed_i;
               sa_d    = op_a_i[WIDTH-1];
               neg_d   = 1'b0;
               c_d     = 1'b0;
               state_d = is_signed_i ? S_ABS_A : S_MUL;
            end
         end

         // Two's-complement absolute value of the multiplicand: ~x + 1
         S_ABS_A: begin
            if (mcand_q[WIDTH-1]) begin
               add_a_o   = ~mcand_q;
               add_cin_o = 1'b1;
               mcand_d   = add_s_i;
            end
            state_d = S_ABS_B;
         end

         // Absolute value of the multiplier (held in the low word)
         S_ABS_B: begin
            if (lo_q[WIDTH-1]) begin
               add_a_o   = ~lo_q;
               add_cin_o = 1'b1;
               lo_d      = add_s_i;
            end
            neg_d   = sa_q ^ lo_q[WIDTH-1];
            state_d = S_MUL;
         end

         // One shift-add step: conditionally add the multiplicand into the
         // high word, then shift {carry, sum, lo} right by one bit
         S_MUL: begin
            add_a_o = hi_q;
            add_b_o = lo_q[0] ? mcand_q : '0;
            hi_d    = {add_cout_i, add_s_i[WIDTH-1:1]};
            lo_d    = {add_s_i[0], lo_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == C_LAST) begin
               state_d = sgn_q ? S_NEG_LO : S_DONE;
            end
         end

         // 64-bit negation, low word first; its carry feeds the high word
         S_NEG_LO: begin
            if (neg_q) begin
               add_a_o   = ~lo_q;
               add_cin_o = 1'b1;
               lo_d      = add_s_i;
               c_d       = add_cout_i;
            end
            state_d = S_NEG_HI;
         end

         S_NEG_HI: begin
            if (neg_q) begin
               add_a_o   = ~hi_q;
               add_cin_o = c_q;
               hi_d      = add_s_i;
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides the normal transition; hi/lo retain partial values
      if (abort_w && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         sa_q    <= 1'b0;
         neg_q   <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         sa_q    <= sa_d;
         neg_q   <= neg_d;
         c_q     <= c_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_mult_seq_ctrl
// Description : Self-checking bench for mult_seq_ctrl with an external adder
//               model and a product scoreboard. Abort steps are compiled in
//               when MULT_ABORT_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_seq_ctrl;

   localparam int W = 32;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic          sgn   = 1'b0;
   logic [W-1:0]  op_a  = '0;
   logic [W-1:0]  op_b  = '0;
`ifdef MULT_ABORT_EN
   logic          abort = 1'b0;
`endif

   wire  [W-1:0]  add_s;
   wire           add_cout;
   wire  [W-1:0]  add_a;
   wire  [W-1:0]  add_b;
   wire           add_cin;
   wire           busy;
   wire           done;
   wire  [W-1:0]  hi;
   wire  [W-1:0]  lo;

   // Shared datapath adder
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

   mult_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
      .clock_i     (clk),
      .reset_i     (rst),
      .start_i     (start),
      .is_signed_i (sgn),
      .op_a_i      (op_a),
      .op_b_i      (op_b),
      .add_s_i     (add_s),
      .add_cout_i  (add_cout),
`ifdef MULT_ABORT_EN
      .abort_i     (abort),
`endif
      .add_a_o     (add_a),
      .add_b_o     (add_b),
      .add_cin_o   (add_cin),
      .busy_o      (busy),
      .done_o      (done),
      .hi_o        (hi),
      .lo_o        (lo)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] sb[$];
   logic [63:0] last_exp = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
      longint sa, sb_;
      if (s) begin
         sa  = longint'($signed(a));
         sb_ = longint'($signed(b));
         return 64'(sa * sb_);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest pending product
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", {63'b0, done}, 64'd0);
         end else begin
            chk("product", {hi, lo}, sb.pop_front());
         end
      end
   end

   // One operation; poke>0 pulses a garbage start while busy at that cycle
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int exp_lat, input int poke);
      int lat, nbusy;
      @(negedge clk);
      op_a = a; op_b = b; sgn = s; start = 1'b1;
      last_exp = model(a, b, s);
      sb.push_back(last_exp);
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; nbusy = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (poke > 0 && k == poke) begin
            start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'h1234_5678; sgn = ~s;
         end
         if (poke > 0 && k == poke + 2) start = 1'b0;
         if (busy) nbusy++;
         if (done) begin lat = k; break; end
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
      chk({tag, "_done"}, {63'b0, done}, 64'd0);
      chk({tag, "_adder"}, {add_a[31:0], add_b[31:0]} | {63'b0, add_cin}, 64'd0);
   endtask

   initial begin
      int t, ndone, d1, d2, d3;

      // Reset state
      repeat (2) @(negedge clk);
      check_idle("reset");
      chk("reset_hilo", {hi, lo}, 64'd0);
      rst = 1'b0;

      // Directed products
      run_op("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 0);
      chk("multu_max_value", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op("mult_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 37, 0);
      chk("mult_m3x7_value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("mult_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 37, 0);
      chk("mult_minmin_value", {hi, lo}, 64'h4000_0000_0000_0000);
      run_op("multu_zero", 32'd0, 32'hDEAD_BEEF, 1'b0, 33, 0);
      run_op("mult_negneg", 32'hFFFF_FF00, 32'h8000_0000, 1'b1, 37, 0);
      run_op("mult_posneg", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 37, 0);
      for (int i = 0; i < 3; i++) begin
         run_op("rand", $urandom, $urandom, 1'(i), i[0] ? 37 : 33, 0);
      end

      // Start while busy is ignored; result then holds steady
      run_op("ignore_start", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 33, 10);
      repeat (5) @(negedge clk);
      chk("hold_hilo", {hi, lo}, last_exp);
      check_idle("hold");

      // Back-to-back with start held high: one op per 34 clocks
      @(negedge clk);
      op_a = 32'hCAFE_F00D; op_b = 32'h0000_1001; sgn = 1'b0; start = 1'b1;
      last_exp = model(op_a, op_b, 1'b0);
      repeat (3) sb.push_back(last_exp);
      ndone = 0; d1 = 0; d2 = 0; d3 = 0;
      for (t = 1; t <= 200 && ndone < 3; t++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (ndone == 1) d1 = t;
            if (ndone == 2) d2 = t;
            if (ndone == 3) begin d3 = t; start = 1'b0; end
         end
      end
      start = 1'b0;
      chk("b2b_count", 64'(ndone), 64'd3);
      chk("b2b_gap1", 64'(d2 - d1), 64'd34);
      chk("b2b_gap2", 64'(d3 - d2), 64'd34);
      repeat (3) @(negedge clk);
      check_idle("b2b_end");

      // Asynchronous reset in the middle of MUL
      @(negedge clk);
      op_a = 32'hFFFF_FFFF; op_b = 32'h0F0F_0F0F; sgn = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", {63'b0, busy}, 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      run_op("after_rst", 32'hFFFF_FFF9, 32'd6, 1'b1, 37, 0);

`ifdef MULT_ABORT_EN
      // Abort at MUL cycle 5 returns to IDLE without a done pulse
      @(negedge clk);
      op_a = 32'h0001_0001; op_b = 32'hFFFF_0000; sgn = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle("abort");
      repeat (40) @(negedge clk);
      run_op("after_abort", 32'h0001_0001, 32'hFFFF_0000, 1'b0, 33, 0);
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
